// File: rtl/instr_encode_loader.sv
// Packs MIPS R-type (and, with ITYPE_ENCODE_EN defined, I-type) instruction fields into
// 32-bit words and writes them sequentially into instruction memory from BASE_ADDR.
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_rtype,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err,
    output logic              done
);

    localparam int unsigned     DEPTH   = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] BASE_W = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [ADDR_W:0]   cnt_r, cnt_s, cnt_inc_s;
    logic              full_r, full_s;
    logic              err_r, err_s;
    logic              we_r, done_r;
    logic              ready_s;
    logic              legal_s;
    logic [31:0]       word_s;

    function automatic logic [31:0] enc_rtype(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                              input logic [4:0] f_rd, input logic [4:0] f_sh,
                                              input logic [5:0] f_fn);
        return {6'b000000, f_rs, f_rt, f_rd, f_sh, f_fn};
    endfunction

`ifdef ITYPE_ENCODE_EN
    function automatic logic [31:0] enc_itype(input logic [5:0] f_op, input logic [4:0] f_rs,
                                              input logic [4:0] f_rt, input logic [15:0] f_imm);
        return {f_op, f_rs, f_rt, f_imm};
    endfunction

    // Select encoding; opcode 0 is reserved for R-type and so illegal as I-type
    always_comb begin
        if (is_rtype) begin
            word_s  = enc_rtype(rs, rt, rd, shamt, funct);
            legal_s = 1'b1;
        end else begin
            word_s  = enc_itype(opcode, rs, rt, imm);
            legal_s = (opcode != 6'd0);
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{opcode, imm};

    // R-type only build: any I-type request is illegal
    always_comb begin
        word_s  = enc_rtype(rs, rt, rd, shamt, funct);
        legal_s = is_rtype;
    end
`endif

    // Next-state, datapath and handshake-ready logic
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        cnt_s     = cnt_r;
        full_s    = full_r;
        err_s     = err_r;
        ready_s   = 1'b0;
        cnt_inc_s = cnt_r + (ADDR_W+1)'(1'b1);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ACCEPT;
                    addr_s  = BASE_W;
                    cnt_s   = {(ADDR_W+1){1'b0}};
                    err_s   = 1'b0;
                    full_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCEPT: begin
                ready_s = !full_r && !start;
                if (start) begin
                    state_s = ACCEPT;
                    addr_s  = BASE_W;
                    cnt_s   = {(ADDR_W+1){1'b0}};
                    err_s   = 1'b0;
                    full_s  = 1'b0;
                end else if (in_valid && ready_s) begin
                    if (legal_s) begin
                        wdata_s = word_s;
                        state_s = WRITE;
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (finish) begin
                    state_s = DONE;
                end else begin
                    state_s = ACCEPT;
                end
            end
            WRITE: begin
                // The address stops on the last word rather than wrapping into the low region
                cnt_s   = cnt_inc_s;
                full_s  = (cnt_inc_s == DEPTH_W);
                addr_s  = full_s ? addr_r : addr_r + ADDR_W'(1'b1);
                state_s = ACCEPT;
            end
            DONE: begin
                if (start) begin
                    state_s = ACCEPT;
                    addr_s  = BASE_W;
                    cnt_s   = {(ADDR_W+1){1'b0}};
                    err_s   = 1'b0;
                    full_s  = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts any pending write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= BASE_W;
            wdata_r <= 32'd0;
            cnt_r   <= {(ADDR_W+1){1'b0}};
            full_r  <= 1'b0;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            cnt_r   <= cnt_s;
            full_r  <= full_s;
            err_r   <= err_s;
            we_r    <= (state_s == WRITE);
            done_r  <= (state_s == DONE);
        end
    end

    assign in_ready   = ready_s;
    assign mem_we     = we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign word_count = cnt_r;
    assign full       = full_r;
    assign err        = err_r;
    assign done       = done_r;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomized self-checking bench for instr_encode_loader against a transaction-level model;
// expectations follow ITYPE_ENCODE_EN the same way the design build does.
module tb_instr_encode_loader;

    localparam int ADDR_W    = 3;
    localparam int BASE_ADDR = 2;
    localparam int DEPTH     = (1 << ADDR_W) - BASE_ADDR;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic              is_rtype;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              err;
    logic              done;

    instr_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .is_rtype(is_rtype),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .full(full),
        .err(err), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          r;
        int unsigned op, f_rs, f_rt, f_rd, sh, fn, im;
    } bundle_t;

    int checks = 0;
    int errors = 0;
    int m_count, m_writes, we_seen;
    bit m_err, m_full;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned encode(input bundle_t b);
        if (b.r)
            return b.f_rs * 32'h0020_0000 + b.f_rt * 32'h0001_0000 + b.f_rd * 32'h0000_0800
                   + b.sh * 32'd64 + b.fn;
        else
            return b.op * 32'h0400_0000 + b.f_rs * 32'h0020_0000 + b.f_rt * 32'h0001_0000 + b.im;
    endfunction

    function automatic bit is_legal(input bundle_t b);
`ifdef ITYPE_ENCODE_EN
        return b.r || (b.op != 0);
`else
        return b.r;
`endif
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.r    = ($urandom_range(0, 1) == 1);
        b.op   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
        b.f_rs = $urandom_range(0, 31);
        b.f_rt = $urandom_range(0, 31);
        b.f_rd = $urandom_range(0, 31);
        b.sh   = $urandom_range(0, 31);
        b.fn   = $urandom_range(0, 63);
        b.im   = $urandom_range(0, 65535);
        return b;
    endfunction

    function automatic bundle_t mk(input bit r, input int unsigned op, input int unsigned a,
                                   input int unsigned t, input int unsigned d,
                                   input int unsigned sh, input int unsigned fn,
                                   input int unsigned im);
        bundle_t b;
        b.r = r; b.op = op; b.f_rs = a; b.f_rt = t; b.f_rd = d; b.sh = sh; b.fn = fn; b.im = im;
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        is_rtype = b.r;
        opcode   = b.op[5:0];
        rs       = b.f_rs[4:0];
        rt       = b.f_rt[4:0];
        rd       = b.f_rd[4:0];
        shamt    = b.sh[4:0];
        funct    = b.fn[5:0];
        imm      = b.im[15:0];
    endtask

    always @(negedge clk) if (mem_we === 1'b1) we_seen++;

    // One bundle through the handshake, then the write cycle (or the error outcome)
    task automatic send(input bundle_t b, input bit fin);
        drive(b);
        in_valid = 1'b1;
        finish   = fin;
        #1;
        check_eq("ready_pre", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        finish   = 1'b0;
        if (is_legal(b)) begin
            check_eq("we_pulse", mem_we, 1);
            check_eq("addr", mem_addr, BASE_ADDR + m_count);
            check_eq("wdata", mem_wdata, encode(b));
            check_eq("ready_in_write", in_ready, 0);
            m_writes++;
            @(posedge clk); #1;
            m_count++;
            m_full = (m_count == DEPTH);
            check_eq("we_drop", mem_we, 0);
            check_eq("count", word_count, m_count);
            check_eq("full", full, m_full);
            check_eq("err_hold", err, m_err);
            check_eq("not_done", done, 0);
            check_eq("ready_post", in_ready, !m_full);
            if (!m_full) check_eq("addr_next", mem_addr, BASE_ADDR + m_count);
        end else begin
            m_err = 1'b1;
            check_eq("illegal_no_we", mem_we, 0);
            check_eq("illegal_err", err, 1);
            check_eq("illegal_count", word_count, m_count);
            check_eq("illegal_ready", in_ready, 1);
        end
    endtask

    task automatic start_session();
        start = 1'b1;
        #1;
        check_eq("ready_during_start", in_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        m_count = 0; m_err = 1'b0; m_full = 1'b0;
        check_eq("start_ready", in_ready, 1);
        check_eq("start_count", word_count, 0);
        check_eq("start_addr", mem_addr, BASE_ADDR);
        check_eq("start_err", err, 0);
        check_eq("start_full", full, 0);
        check_eq("start_done", done, 0);
    endtask

    task automatic finish_session();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        check_eq("done_set", done, 1);
        check_eq("done_ready", in_ready, 0);
        check_eq("done_count", word_count, m_count);
        check_eq("done_err", err, m_err);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("done_hold", done, 1);
        check_eq("done_no_we", mem_we, 0);
        check_eq("done_ready_valid", in_ready, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        bundle_t b;
        m_count = 0; m_writes = 0; we_seen = 0; m_err = 1'b0; m_full = 1'b0;
        rst_n = 1'b0; start = 1'b1; finish = 1'b1; in_valid = 1'b1;
        drive(rand_bundle());

        // Reset with stimulus active
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", in_ready, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, BASE_ADDR);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_count", word_count, 0);
        check_eq("rst_flags", {full, err, done}, 0);
        rst_n = 1'b1; start = 1'b0; finish = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_ready", in_ready, 0);
        check_eq("idle_we", mem_we, 0);
        in_valid = 1'b0;

        // Directed encodings and control corner cases
        start_session();
        send(mk(1'b1, 0, 1, 2, 3, 0, 32'h20, 0), 1'b0);
        check_eq("rtype_word_seen", m_writes, 1);
        send(mk(1'b0, 32'h08, 1, 2, 0, 0, 0, 32'h0005), 1'b0);
        send(mk(1'b0, 0, 7, 9, 0, 0, 0, 32'h1234), 1'b0);
        send(mk(1'b1, 0, 31, 31, 31, 31, 63, 0), 1'b1);
        check_eq("err_sticky", err, 1);
        finish_session();
        start_session();

        // Randomized sessions, some running into the full condition
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(3, 12);
            for (int k = 0; k < n; k++) begin
                if (!m_full) send(rand_bundle(), ($urandom_range(0, 7) == 0));
            end
            if (m_full) begin
                drive(rand_bundle());
                in_valid = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    check_eq("full_ready", in_ready, 0);
                    check_eq("full_no_we", mem_we, 0);
                    check_eq("full_count", word_count, DEPTH);
                end
                in_valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) finish_session();
            start_session();
        end

        // Reset asserted during the write cycle
        drive(mk(1'b1, 0, 4, 5, 6, 7, 8, 0));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("wr_before_rst", mem_we, 1);
        m_writes++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rst_abort_we", mem_we, 0);
        check_eq("rst_abort_count", word_count, 0);
        check_eq("rst_abort_addr", mem_addr, BASE_ADDR);
        check_eq("rst_abort_ready", in_ready, 0);
        @(posedge clk); #1;
        check_eq("write_total", we_seen, m_writes);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
